// File: rtl/pd_alu_pkg.sv
// Shared ALU operation encoding and the combinational compute function used by
// elastic_alu_pipe. The function works at a fixed maximum width; callers zero-extend.
package pd_alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SRA = 3'd7
  } alu_op_e;

  localparam int ALU_MAX_W = 64;

  // op1/op2 must arrive zero-extended above `width`; the caller truncates the result.
  function automatic logic [ALU_MAX_W-1:0] alu_compute(
    input alu_op_e                op,
    input logic [ALU_MAX_W-1:0]   op1,
    input logic [ALU_MAX_W-1:0]   op2,
    input int                     width
  );
    logic [ALU_MAX_W-1:0] fill;
    logic [ALU_MAX_W-1:0] op1_sx;
    logic [5:0]           shamt;
    logic                 sign;
    shamt  = op2[5:0] & 6'(width - 1);
    fill   = ~((ALU_MAX_W'(1) << width) - ALU_MAX_W'(1));
    sign   = |(op1 & (ALU_MAX_W'(1) << (width - 1)));
    op1_sx = sign ? (op1 | fill) : op1;
    case (op)
      ALU_ADD: alu_compute = op1 + op2;
      ALU_SUB: alu_compute = op1 - op2;
      ALU_AND: alu_compute = op1 & op2;
      ALU_OR:  alu_compute = op1 | op2;
      ALU_XOR: alu_compute = op1 ^ op2;
      ALU_SLL: alu_compute = op1 << shamt;
      ALU_SRL: alu_compute = op1 >> shamt;
      ALU_SRA: alu_compute = $signed(op1_sx) >>> shamt;
      default: alu_compute = '0;
    endcase
  endfunction

endpackage

// File: rtl/elastic_stage.sv
// One elastic register slice: holds a payload when downstream stalls, refills when empty.
module elastic_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          up_valid,
  input  logic [DW-1:0] up_data,
  output logic          up_ready,
  output logic          dn_valid,
  output logic [DW-1:0] dn_data,
  input  logic          dn_ready
);

  assign up_ready = !dn_valid || dn_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (flush) begin
      dn_valid <= 1'b0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) dn_data <= up_data;
    end
  end

endmodule

// File: rtl/elastic_alu_pipe.sv
// Back-pressurable ALU pipeline: result computed ahead of stage 0, then carried
// with its zero flag and tag through STAGES elastic slices.
module elastic_alu_pipe
  import pd_alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_op1,
  input  logic [WIDTH-1:0] in_op2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int DW = WIDTH + 1 + TAG_W;

  logic [WIDTH-1:0] res;
  logic             stg_valid [STAGES+1];
  logic             stg_ready [STAGES+1];
  logic [DW-1:0]    stg_data  [STAGES+1];

  always_comb begin
    res = WIDTH'(alu_compute(alu_op_e'(in_op), ALU_MAX_W'(in_op1), ALU_MAX_W'(in_op2), WIDTH));
  end

  assign stg_valid[0]      = in_valid;
  assign stg_data[0]       = {res, (res == '0), in_tag};
  assign stg_ready[STAGES] = out_ready;

  // Gating with flush keeps the producer from seeing a handshake on a flush edge.
  assign in_ready = stg_ready[0] && !flush;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    elastic_stage #(.DW(DW)) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .up_valid (stg_valid[i]),
      .up_data  (stg_data[i]),
      .up_ready (stg_ready[i]),
      .dn_valid (stg_valid[i+1]),
      .dn_data  (stg_data[i+1]),
      .dn_ready (stg_ready[i+1])
    );
  end

  assign out_valid                    = stg_valid[STAGES];
  assign {out_res, out_zero, out_tag} = stg_data[STAGES];

endmodule

// File: tb/tb_elastic_alu_pipe.sv
// Directed bench for elastic_alu_pipe with a queue scoreboard fed on input handshakes.
module tb_elastic_alu_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_op1;
  logic [31:0] in_op2;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic        out_zero;
  logic [3:0]  out_tag;

  elastic_alu_pipe #(.WIDTH(32), .STAGES(3), .TAG_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_op1    (in_op1),
    .in_op2    (in_op2),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_zero  (out_zero),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic [3:0]  tag;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   first_out, last_out, n_out;
  logic last_in_acc;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (op)
      3'd0: model = a + b;
      3'd1: model = a - b;
      3'd2: model = a & b;
      3'd3: model = a | b;
      3'd4: model = a ^ b;
      3'd5: model = a << b[4:0];
      3'd6: model = a >> b[4:0];
      default: model = sa >>> b[4:0];
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Called at a negedge; samples handshakes mid-cycle, then advances to the next negedge.
  task automatic clk_step();
    exp_t e;
    #1;
    last_in_acc = in_valid && in_ready;
    if (flush) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("res", out_res, e.res);
          check("zero", {31'd0, out_zero}, {31'd0, e.zero});
          check("tag", {28'd0, out_tag}, {28'd0, e.tag});
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        n_out++;
      end
      if (last_in_acc) begin
        e.res  = model(in_op, in_op1, in_op2);
        e.zero = (e.res == 32'd0);
        e.tag  = in_tag;
        q.push_back(e);
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    in_op    = op;
    in_op1   = a;
    in_op2   = b;
    in_tag   = tag;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      clk_step();
      if (last_in_acc) break;
    end
    check("send_accept", {31'd0, last_in_acc}, 32'd1);
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && q.size() > 0; k++) clk_step();
    check("drain_empty", q.size(), 32'd0);
  endtask

  initial begin
    int   lat, n_acc, seen;
    logic [31:0] hold_res;
    logic [3:0]  hold_tag;

    first_out = -1; last_out = -1; n_out = 0;
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_op = 3'd0; in_op1 = 32'd7; in_op2 = 32'd9; in_tag = 4'd3;

    // Reset held with a valid op offered
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_res", out_res, 32'd0);
    check("rst_out_zero", {31'd0, out_zero}, 32'd0);
    check("rst_out_tag", {28'd0, out_tag}, 32'd0);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid) seen++;
      clk_step();
    end
    check("rst_nothing_emitted", seen, 32'd0);

    // Latency and wrap-to-zero
    in_op = 3'd0; in_op1 = 32'hFFFF_FFFF; in_op2 = 32'd1; in_tag = 4'd5; in_valid = 1'b1;
    clk_step();
    check("lat_accept", {31'd0, last_in_acc}, 32'd1);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      clk_step();
      lat++;
    end
    check("latency", lat, 32'd3);
    check("add_wrap_res", out_res, 32'd0);
    check("add_wrap_zero", {31'd0, out_zero}, 32'd1);
    check("add_wrap_tag", {28'd0, out_tag}, 32'd5);
    drain(10);

    // Back-to-back throughput
    first_out = -1; n_out = 0;
    send(3'd1, 32'd10, 32'd3, 4'd0);
    send(3'd2, 32'h0000_F0F0, 32'h0000_FF00, 4'd1);
    send(3'd3, 32'h0000_F0F0, 32'h0000_0F0F, 4'd2);
    send(3'd4, 32'h0000_00FF, 32'h0000_00FF, 4'd3);
    send(3'd0, 32'd100, 32'd23, 4'd4);
    in_valid = 1'b0;
    drain(20);
    check("b2b_count", n_out, 32'd5);
    check("b2b_consecutive", last_out - first_out, 32'd4);

    // Back-pressure: fill, hold, then simultaneous accept/emit
    out_ready = 1'b0;
    n_acc = 0;
    for (int k = 0; k < 4; k++) begin
      in_op = 3'd0; in_op1 = 32'(k * 16); in_op2 = 32'(k + 1); in_tag = 4'(k + 6);
      in_valid = 1'b1;
      clk_step();
      if (!last_in_acc) break;
      n_acc++;
    end
    check("bp_accepted", n_acc, 32'd3);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    hold_res = out_res;
    hold_tag = out_tag;
    clk_step();
    clk_step();
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_res_stable", out_res, hold_res);
    check("bp_tag_stable", {28'd0, out_tag}, {28'd0, hold_tag});
    check("bp_still_full", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    clk_step();
    check("bp_fourth_same_cycle", {31'd0, last_in_acc}, 32'd1);
    in_valid = 1'b0;
    drain(20);

    // Shifts: only op2[4:0] is used
    send(3'd7, 32'h8000_0000, 32'd33, 4'd10);
    send(3'd6, 32'h8000_0000, 32'd33, 4'd11);
    send(3'd5, 32'h0000_0001, 32'd31, 4'd12);
    send(3'd7, 32'h7000_0000, 32'd4, 4'd13);
    in_valid = 1'b0;
    drain(20);

    // Flush with two ops in flight
    out_ready = 1'b0;
    send(3'd0, 32'd1, 32'd1, 4'd9);
    send(3'd0, 32'd2, 32'd2, 4'd10);
    in_op = 3'd0; in_op1 = 32'd3; in_op2 = 32'd3; in_tag = 4'd11; in_valid = 1'b1;
    flush = 1'b1;
    #1;
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    clk_step();
    check("flush_no_accept", {31'd0, last_in_acc}, 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) seen++;
      clk_step();
    end
    check("flush_no_ghosts", seen, 32'd0);

    // Asynchronous reset mid-stream
    send(3'd0, 32'd5, 32'd6, 4'd1);
    send(3'd1, 32'd50, 32'd6, 4'd2);
    send(3'd4, 32'hAAAA_5555, 32'h0F0F_F0F0, 4'd3);
    check("mid_out_valid_before", {31'd0, out_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_res", out_res, 32'd0);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_idle", {31'd0, out_valid}, 32'd0);
    send(3'd0, 32'd2, 32'd2, 4'd14);
    in_valid = 1'b0;
    drain(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
